// File: rtl/prio_encoder_4to2_seq_if.sv
// rtl/prio_encoder_4to2_seq_if.sv - request/acknowledge bus of the sequential 4-to-2 priority encoder
interface prio_encoder_4to2_seq_if #(
  parameter int N_IN   = 4,
  parameter int CODE_W = 2
);
  logic              en;
  logic [N_IN-1:0]   d;
  logic              ack;
  logic [CODE_W-1:0] y;
  logic              valid;
  logic [N_IN-1:0]   pend;
  logic              ovf;

  modport master (
    output en, d, ack,
    input  y, valid, pend, ovf
  );

  modport slave (
    input  en, d, ack,
    output y, valid, pend, ovf
  );
endinterface

// File: rtl/prio_encoder_4to2_seq.sv
// rtl/prio_encoder_4to2_seq.sv - latches one-hot requests and serves them as 2-bit codes, highest index first
module prio_encoder_4to2_seq (
  input  logic                      clk,
  input  logic                      rst,
  prio_encoder_4to2_seq_if.slave    bus
);
  localparam int N_IN   = 4;
  localparam int CODE_W = 2;

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t            state_q, state_d;
  logic [CODE_W-1:0] y_q, y_d;
  logic              valid_q, valid_d;
  logic [N_IN-1:0]   pend_q, pend_d;
  logic              ovf_q, ovf_d;

  logic [N_IN-1:0]   nd;
  logic [N_IN-1:0]   e;
  logic [CODE_W-1:0] w;
  logic [N_IN-1:0]   w_mask;

  function automatic logic [CODE_W-1:0] prio(input logic [N_IN-1:0] v);
    logic [CODE_W-1:0] r;
    r = '0;
    casez (v)
      4'b1???: r = 2'd3;
      4'b01??: r = 2'd2;
      4'b001?: r = 2'd1;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  always_comb begin
    nd     = bus.en ? bus.d : '0;
    e      = pend_q | nd;
    w      = prio(e);
    w_mask = '0;
    w_mask[w] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    // Duplicates merge into pend; only the fact that one happened is remembered.
    ovf_d   = ovf_q | (|(nd & pend_q));
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (e != '0) begin
          y_d     = w;
          valid_d = 1'b1;
          pend_d  = e & ~w_mask;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (!bus.ack) begin
          pend_d = pend_q | nd;
        end else if (e != '0) begin
          y_d    = w;
          pend_d = e & ~w_mask;
        end else begin
          valid_d = 1'b0;
          pend_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      valid_q <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.y     = y_q;
  assign bus.valid = valid_q;
  assign bus.pend  = pend_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_prio_encoder_4to2_seq.sv
// tb/tb_prio_encoder_4to2_seq.sv - directed self-checking bench for prio_encoder_4to2_seq
module tb_prio_encoder_4to2_seq;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  prio_encoder_4to2_seq_if bus ();

  prio_encoder_4to2_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // y, valid, pend, ovf in one go
  task automatic chk_all(input string tag, input logic [1:0] y, input logic v,
                         input logic [3:0] p, input logic o);
    chk({tag, ".y"},     {6'd0, bus.y},     {6'd0, y});
    chk({tag, ".valid"}, {7'd0, bus.valid}, {7'd0, v});
    chk({tag, ".pend"},  {4'd0, bus.pend},  {4'd0, p});
    chk({tag, ".ovf"},   {7'd0, bus.ovf},   {7'd0, o});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.en   = 1'b1;
    bus.d    = 4'hF;
    bus.ack  = 1'b0;

    // reset held with all requests active
    tick(); chk_all("rst0", 2'd0, 1'b0, 4'h0, 1'b0);
    tick(); chk_all("rst1", 2'd0, 1'b0, 4'h0, 1'b0);

    // single request on line 2
    rst = 1'b0; bus.d = 4'b0100;
    tick(); chk_all("single_cap", 2'd2, 1'b1, 4'h0, 1'b0);
    bus.d = 4'b0000;
    tick(); chk_all("single_hold", 2'd2, 1'b1, 4'h0, 1'b0);
    bus.ack = 1'b1;
    tick(); chk_all("single_ack", 2'd2, 1'b0, 4'h0, 1'b0);

    // priority drain with ack held high
    bus.d = 4'b1011;
    tick(); chk_all("drain3", 2'd3, 1'b1, 4'b0011, 1'b0);
    bus.d = 4'b0000;
    tick(); chk_all("drain1", 2'd1, 1'b1, 4'b0001, 1'b0);
    tick(); chk_all("drain0", 2'd0, 1'b1, 4'b0000, 1'b0);
    tick(); chk_all("drain_end", 2'd0, 1'b0, 4'b0000, 1'b0);
    bus.ack = 1'b0;

    // enable gating
    bus.en = 1'b0; bus.d = 4'hF;
    tick(); chk_all("gate0", 2'd0, 1'b0, 4'h0, 1'b0);
    tick(); chk_all("gate1", 2'd0, 1'b0, 4'h0, 1'b0);
    bus.en = 1'b1;
    tick(); chk_all("gate_open", 2'd3, 1'b1, 4'b0111, 1'b0);
    bus.en = 1'b0; bus.ack = 1'b1;
    tick(); chk_all("gate_d2", 2'd2, 1'b1, 4'b0011, 1'b0);
    tick(); chk_all("gate_d1", 2'd1, 1'b1, 4'b0001, 1'b0);
    tick(); chk_all("gate_d0", 2'd0, 1'b1, 4'b0000, 1'b0);
    tick(); chk_all("gate_end", 2'd0, 1'b0, 4'b0000, 1'b0);
    bus.ack = 1'b0;

    // overflow, then re-request of the line being acked
    bus.en = 1'b1; bus.d = 4'b0011;
    tick(); chk_all("ovf_cap", 2'd1, 1'b1, 4'b0001, 1'b0);
    bus.d = 4'b0001;
    tick(); chk_all("ovf_set", 2'd1, 1'b1, 4'b0001, 1'b1);
    bus.d = 4'b0010; bus.ack = 1'b1;
    tick(); chk_all("rereq", 2'd1, 1'b1, 4'b0001, 1'b1);
    bus.d = 4'b0000;
    tick(); chk_all("rereq_l0", 2'd0, 1'b1, 4'b0000, 1'b1);
    tick(); chk_all("rereq_end", 2'd0, 1'b0, 4'b0000, 1'b1);
    bus.ack = 1'b0;

    // reset in the middle of service
    bus.d = 4'b0111;
    tick(); chk_all("mid_cap", 2'd2, 1'b1, 4'b0011, 1'b1);
    bus.d = 4'b0000; rst = 1'b1;
    tick(); chk_all("mid_rst", 2'd0, 1'b0, 4'b0000, 1'b0);
    rst = 1'b0;
    tick(); chk_all("post_rst0", 2'd0, 1'b0, 4'b0000, 1'b0);
    bus.ack = 1'b1;
    tick(); chk_all("post_rst_ack", 2'd0, 1'b0, 4'b0000, 1'b0);
    bus.ack = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
